// File: rtl/axi4_ram_if.sv
// AXI4 bus bundle between a manager and the axi4_ram slave.
// Channel signals only; clock and reset travel as plain ports.
interface axi4_ram_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 20,
    parameter int ID_WIDTH   = 8
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi4_ram.sv
// AXI4 slave RAM with independent write and read burst engines.
// Responses are always OKAY; lock, cache, prot and wlast are not used.
module axi4_ram #(
    parameter  int DATA_WIDTH = 64,
    parameter  int ADDR_WIDTH = 20,
    parameter  int ID_WIDTH   = 8,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic clk,
    input  logic areset_n,
    axi4_ram_if.slave s_axi
);
    localparam int ADDR_LSB  = $clog2(STRB_WIDTH);
    localparam int IDX_WIDTH = ADDR_WIDTH - ADDR_LSB;
    localparam int MEM_WORDS = 2 ** IDX_WIDTH;

    typedef enum logic {W_IDLE, W_BURST} wState_t;
    typedef enum logic {R_IDLE, R_BURST} rState_t;

    logic [DATA_WIDTH-1:0] mem [0:MEM_WORDS-1];

    function automatic logic [ADDR_WIDTH-1:0] nextAddr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst);
        if (burst == 2'b00) return addr;
        return addr + (ADDR_WIDTH'(1) << size);
    endfunction

    // Holds both ready outputs low until the first edge after reset release.
    logic live_q;
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) live_q <= 1'b0;
        else           live_q <= 1'b1;
    end

    wState_t               wState_q, wState_d;
    logic [ID_WIDTH-1:0]   awId_q, awId_d;
    logic [ADDR_WIDTH-1:0] awAddr_q, awAddr_d;
    logic [7:0]            awLen_q, awLen_d;
    logic [2:0]            awSize_q, awSize_d;
    logic [1:0]            awBurst_q, awBurst_d;
    logic [7:0]            wCnt_q, wCnt_d;
    logic                  bValid_q, bValid_d;
    logic [ID_WIDTH-1:0]   bId_q, bId_d;
    logic                  awReady, wReady, awHs, wHs;
    logic [IDX_WIDTH-1:0]  wWordIdx;

    assign awReady  = live_q && (wState_q == W_IDLE) && !(bValid_q && !s_axi.bready);
    assign wReady   = (wState_q == W_BURST);
    assign awHs     = s_axi.awvalid && awReady;
    assign wHs      = s_axi.wvalid && wReady;
    assign wWordIdx = awAddr_q[ADDR_WIDTH-1:ADDR_LSB];

    always_comb begin
        wState_d  = wState_q;
        awId_d    = awId_q;
        awAddr_d  = awAddr_q;
        awLen_d   = awLen_q;
        awSize_d  = awSize_q;
        awBurst_d = awBurst_q;
        wCnt_d    = wCnt_q;
        bValid_d  = bValid_q;
        bId_d     = bId_q;
        if (bValid_q && s_axi.bready) bValid_d = 1'b0;
        case (wState_q)
            W_IDLE: begin
                if (awHs) begin
                    awId_d    = s_axi.awid;
                    awAddr_d  = s_axi.awaddr;
                    awLen_d   = s_axi.awlen;
                    awSize_d  = s_axi.awsize;
                    awBurst_d = s_axi.awburst;
                    wCnt_d    = 8'd0;
                    wState_d  = W_BURST;
                end
            end
            W_BURST: begin
                // The beat count ends the burst; wlast is deliberately not consulted.
                if (wHs) begin
                    awAddr_d = nextAddr(awAddr_q, awSize_q, awBurst_q);
                    wCnt_d   = wCnt_q + 8'd1;
                    if (wCnt_q == awLen_q) begin
                        wState_d = W_IDLE;
                        bValid_d = 1'b1;
                        bId_d    = awId_q;
                    end
                end
            end
            default: wState_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            wState_q  <= W_IDLE;
            awId_q    <= '0;
            awAddr_q  <= '0;
            awLen_q   <= '0;
            awSize_q  <= '0;
            awBurst_q <= '0;
            wCnt_q    <= '0;
            bValid_q  <= 1'b0;
            bId_q     <= '0;
        end else begin
            wState_q  <= wState_d;
            awId_q    <= awId_d;
            awAddr_q  <= awAddr_d;
            awLen_q   <= awLen_d;
            awSize_q  <= awSize_d;
            awBurst_q <= awBurst_d;
            wCnt_q    <= wCnt_d;
            bValid_q  <= bValid_d;
            bId_q     <= bId_d;
        end
    end

    // Storage is never reset so partially written bursts survive an abort.
    always_ff @(posedge clk) begin
        if (wHs) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (s_axi.wstrb[i]) mem[wWordIdx][i*8 +: 8] <= s_axi.wdata[i*8 +: 8];
            end
        end
    end

    rState_t               rState_q, rState_d;
    logic [ID_WIDTH-1:0]   arId_q, arId_d;
    logic [ADDR_WIDTH-1:0] arAddr_q, arAddr_d;
    logic [7:0]            arLen_q, arLen_d;
    logic [2:0]            arSize_q, arSize_d;
    logic [1:0]            arBurst_q, arBurst_d;
    logic [7:0]            rCnt_q, rCnt_d;
    logic                  rValid_q, rValid_d;
    logic                  rLast_q, rLast_d;
    logic [DATA_WIDTH-1:0] rData_q;
    logic                  arReady, arHs, rHs, rFetch;
    logic [IDX_WIDTH-1:0]  rWordIdx;

    assign arReady  = live_q && (rState_q == R_IDLE);
    assign arHs     = s_axi.arvalid && arReady;
    assign rHs      = rValid_q && s_axi.rready;
    assign rFetch   = (rState_q == R_BURST) && (!rValid_q || (s_axi.rready && !rLast_q));
    assign rWordIdx = arAddr_q[ADDR_WIDTH-1:ADDR_LSB];

    always_comb begin
        rState_d  = rState_q;
        arId_d    = arId_q;
        arAddr_d  = arAddr_q;
        arLen_d   = arLen_q;
        arSize_d  = arSize_q;
        arBurst_d = arBurst_q;
        rCnt_d    = rCnt_q;
        rValid_d  = rValid_q;
        rLast_d   = rLast_q;
        case (rState_q)
            R_IDLE: begin
                if (arHs) begin
                    arId_d    = s_axi.arid;
                    arAddr_d  = s_axi.araddr;
                    arLen_d   = s_axi.arlen;
                    arSize_d  = s_axi.arsize;
                    arBurst_d = s_axi.arburst;
                    rCnt_d    = 8'd0;
                    rState_d  = R_BURST;
                end
            end
            R_BURST: begin
                if (rFetch) begin
                    arAddr_d = nextAddr(arAddr_q, arSize_q, arBurst_q);
                    rCnt_d   = rCnt_q + 8'd1;
                    rValid_d = 1'b1;
                    rLast_d  = (rCnt_q == arLen_q);
                end else if (rHs) begin
                    rValid_d = 1'b0;
                    rLast_d  = 1'b0;
                    rState_d = R_IDLE;
                end
            end
            default: rState_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            rState_q  <= R_IDLE;
            arId_q    <= '0;
            arAddr_q  <= '0;
            arLen_q   <= '0;
            arSize_q  <= '0;
            arBurst_q <= '0;
            rCnt_q    <= '0;
            rValid_q  <= 1'b0;
            rLast_q   <= 1'b0;
            rData_q   <= '0;
        end else begin
            rState_q  <= rState_d;
            arId_q    <= arId_d;
            arAddr_q  <= arAddr_d;
            arLen_q   <= arLen_d;
            arSize_q  <= arSize_d;
            arBurst_q <= arBurst_d;
            rCnt_q    <= rCnt_d;
            rValid_q  <= rValid_d;
            rLast_q   <= rLast_d;
            if (rFetch) rData_q <= mem[rWordIdx];
        end
    end

    assign s_axi.awready = awReady;
    assign s_axi.wready  = wReady;
    assign s_axi.bid     = bId_q;
    assign s_axi.bresp   = 2'b00;
    assign s_axi.bvalid  = bValid_q;
    assign s_axi.arready = arReady;
    assign s_axi.rid     = arId_q;
    assign s_axi.rdata   = rData_q;
    assign s_axi.rresp   = 2'b00;
    assign s_axi.rlast   = rLast_q;
    assign s_axi.rvalid  = rValid_q;

    logic unusedSignals;
    assign unusedSignals = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot,
                             s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.wlast};
endmodule

// File: tb/tb_axi4_ram.sv
// Directed bench for axi4_ram: single-beat vector table followed by
// hand-written burst, backpressure, concurrency and reset sequences.
module tb_axi4_ram;
    localparam int DW = 64;
    localparam int AW = 20;
    localparam int IW = 8;

    logic clk = 1'b0;
    logic areset_n = 1'b0;
    always #5 clk = ~clk;

    axi4_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

    axi4_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
        .clk      (clk),
        .areset_n (areset_n),
        .s_axi    (bus.slave)
    );

    typedef struct {
        logic [19:0] wAddr;
        logic [63:0] wData;
        logic [7:0]  wStrb;
        logic [7:0]  id;
        logic [19:0] rAddr;
        logic [63:0] expData;
    } vec_t;

    vec_t        vecs [6];
    int          checks = 0;
    int          failures = 0;
    logic [63:0] wBeats [256];
    logic [7:0]  wStrbs [256];
    logic [63:0] rBeats [256];
    logic        rLasts [256];
    logic [7:0]  rIds [256];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: timed out, got no handshake, expected one within the bound", name);
    endtask

    task automatic axiWrite(input logic [7:0] id, input logic [19:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int guard = 0;
        @(negedge clk);
        bus.awid = id; bus.awaddr = addr; bus.awlen = len;
        bus.awsize = size; bus.awburst = burst; bus.awvalid = 1'b1;
        while (!bus.awready && guard < 50) begin @(negedge clk); guard++; end
        if (guard >= 50) timeoutFail("aw_handshake");
        @(negedge clk);
        bus.awvalid = 1'b0;
        checkOutput("wready_latency", 64'(bus.wready), 64'd1);
        for (int k = 0; k <= int'(len); k++) begin
            bus.wdata = wBeats[k]; bus.wstrb = wStrbs[k];
            bus.wlast = (k == int'(len)); bus.wvalid = 1'b1;
            guard = 0;
            while (!bus.wready && guard < 50) begin @(negedge clk); guard++; end
            if (guard >= 50) timeoutFail("w_handshake");
            @(negedge clk);
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        checkOutput("bvalid_latency", 64'(bus.bvalid), 64'd1);
    endtask

    task automatic collectB(input string name, input logic [7:0] expId);
        int guard = 0;
        bus.bready = 1'b1;
        while (!bus.bvalid && guard < 50) begin @(negedge clk); guard++; end
        if (guard >= 50) timeoutFail({name, "_b"});
        else begin
            checkOutput({name, "_bid"}, 64'(bus.bid), 64'(expId));
            checkOutput({name, "_bresp"}, 64'(bus.bresp), 64'd0);
        end
        @(negedge clk);
        bus.bready = 1'b0;
        checkOutput({name, "_bvalid_clear"}, 64'(bus.bvalid), 64'd0);
    endtask

    task automatic axiRead(input logic [7:0] id, input logic [19:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input bit toggle);
        int guard = 0;
        int beat = 0;
        bit seenValid = 0;
        bit stalled = 0;
        logic [63:0] stallData = '0;
        @(negedge clk);
        bus.arid = id; bus.araddr = addr; bus.arlen = len;
        bus.arsize = 3'd3; bus.arburst = burst; bus.arvalid = 1'b1;
        while (!bus.arready && guard < 50) begin @(negedge clk); guard++; end
        if (guard >= 50) timeoutFail("ar_handshake");
        @(negedge clk);
        bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        checkOutput("rvalid_not_early", 64'(bus.rvalid), 64'd0);
        guard = 0;
        while (beat <= int'(len) && guard < 600) begin
            @(negedge clk);
            guard++;
            if (stalled) begin
                checkOutput("rdata_stable_stall", bus.rdata, stallData);
                checkOutput("rvalid_stable_stall", 64'(bus.rvalid), 64'd1);
            end
            bus.rready = toggle ? ~bus.rready : 1'b1;
            if (bus.rvalid && !seenValid) begin
                seenValid = 1;
                checkOutput("rvalid_latency", 64'(guard), 64'd1);
            end
            if (bus.rvalid && bus.rready) begin
                rBeats[beat] = bus.rdata;
                rLasts[beat] = bus.rlast;
                rIds[beat]   = bus.rid;
                beat++;
            end
            stalled   = bus.rvalid && !bus.rready;
            stallData = bus.rdata;
        end
        if (guard >= 600) timeoutFail("r_beats");
        @(negedge clk);
        bus.rready = 1'b0;
        checkOutput("rvalid_clear", 64'(bus.rvalid), 64'd0);
    endtask

    // One table row: single-beat write, B response, single-beat read back.
    task automatic applyStimulus(input vec_t v);
        wBeats[0] = v.wData;
        wStrbs[0] = v.wStrb;
        axiWrite(v.id, v.wAddr, 8'd0, 3'd3, 2'b01);
        collectB("vec", v.id);
        axiRead(v.id ^ 8'h80, v.rAddr, 8'd0, 2'b01, 0);
        checkOutput("vec_rdata", rBeats[0], v.expData);
        checkOutput("vec_rlast", 64'(rLasts[0]), 64'd1);
        checkOutput("vec_rid", 64'(rIds[0]), 64'(v.id ^ 8'h80));
    endtask

    initial begin
        int guard;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awlock = '0; bus.awcache = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.arlock = '0; bus.arcache = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

        vecs[0] = '{20'h00100, 64'h1122334455667788, 8'hFF, 8'h01, 20'h00100, 64'h1122334455667788};
        vecs[1] = '{20'h00200, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 8'h02, 20'h00200, 64'hFFFFFFFFFFFFFFFF};
        vecs[2] = '{20'h00200, 64'h0000000000000000, 8'h0F, 8'h03, 20'h00200, 64'hFFFFFFFF00000000};
        vecs[3] = '{20'h00200, 64'hDEADBEEFCAFEF00D, 8'hF0, 8'h04, 20'h00200, 64'hDEADBEEF00000000};
        vecs[4] = '{20'h00305, 64'hA5A5A5A55A5A5A5A, 8'hFF, 8'h05, 20'h00300, 64'hA5A5A5A55A5A5A5A};
        vecs[5] = '{20'hFFFF8, 64'h0123456789ABCDEF, 8'hFF, 8'h06, 20'hFFFFF, 64'h0123456789ABCDEF};

        repeat (3) @(negedge clk);
        checkOutput("reset_awready", 64'(bus.awready), 64'd0);
        checkOutput("reset_arready", 64'(bus.arready), 64'd0);
        checkOutput("reset_wready", 64'(bus.wready), 64'd0);
        checkOutput("reset_bvalid", 64'(bus.bvalid), 64'd0);
        checkOutput("reset_rvalid", 64'(bus.rvalid), 64'd0);
        checkOutput("reset_rdata", bus.rdata, 64'd0);
        checkOutput("reset_rlast", 64'(bus.rlast), 64'd0);
        areset_n = 1'b1;
        #1;
        checkOutput("awready_before_edge", 64'(bus.awready), 64'd0);
        @(negedge clk);
        checkOutput("awready_after_edge", 64'(bus.awready), 64'd1);
        checkOutput("arready_after_edge", 64'(bus.arready), 64'd1);

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        // 8-beat INCR burst, data k+1
        for (int k = 0; k < 8; k++) begin wBeats[k] = 64'(k + 1); wStrbs[k] = 8'hFF; end
        axiWrite(8'h11, 20'h01000, 8'd7, 3'd3, 2'b01);
        collectB("incr", 8'h11);
        axiRead(8'h12, 20'h01000, 8'd7, 2'b01, 0);
        for (int k = 0; k < 8; k++) begin
            checkOutput("incr_rdata", rBeats[k], 64'(k + 1));
            checkOutput("incr_rlast", 64'(rLasts[k]), 64'(k == 7));
        end

        // FIXED burst keeps only the last beat
        for (int k = 0; k < 4; k++) wBeats[k] = 64'hF1 + 64'(k);
        axiWrite(8'h21, 20'h02000, 8'd3, 3'd3, 2'b00);
        collectB("fixed", 8'h21);
        axiRead(8'h22, 20'h02000, 8'd0, 2'b01, 0);
        checkOutput("fixed_rdata", rBeats[0], 64'hF4);

        // Narrow 4-byte INCR beats land in the two halves of one word
        wBeats[0] = 64'h0000000011111111; wStrbs[0] = 8'h0F;
        wBeats[1] = 64'h2222222200000000; wStrbs[1] = 8'hF0;
        axiWrite(8'h31, 20'h03000, 8'd1, 3'd2, 2'b01);
        collectB("narrow", 8'h31);
        axiRead(8'h32, 20'h03000, 8'd0, 2'b01, 0);
        checkOutput("narrow_rdata", rBeats[0], 64'h2222222211111111);

        // Burst across the top of memory wraps to address 0
        for (int k = 0; k < 3; k++) begin wBeats[k] = 64'hAA01 + 64'(k); wStrbs[k] = 8'hFF; end
        axiWrite(8'h41, 20'hFFFF0, 8'd2, 3'd3, 2'b01);
        collectB("topwrap", 8'h41);
        axiRead(8'h42, 20'hFFFF8, 8'd1, 2'b01, 0);
        checkOutput("topwrap_beat0", rBeats[0], 64'hAA02);
        checkOutput("topwrap_beat1", rBeats[1], 64'hAA03);

        // Read with rready toggling every cycle
        axiRead(8'h51, 20'h01000, 8'd3, 2'b01, 1);
        for (int k = 0; k < 4; k++) checkOutput("toggle_rdata", rBeats[k], 64'(k + 1));
        checkOutput("toggle_rlast", 64'(rLasts[3]), 64'd1);

        // bready held low keeps bvalid up and awready down
        wBeats[0] = 64'h55; wStrbs[0] = 8'hFF;
        axiWrite(8'h61, 20'h00500, 8'd0, 3'd3, 2'b01);
        for (int c = 0; c < 5; c++) begin
            checkOutput("bhold_bvalid", 64'(bus.bvalid), 64'd1);
            checkOutput("bhold_awready", 64'(bus.awready), 64'd0);
            @(negedge clk);
        end
        collectB("bhold", 8'h61);

        // Write and read issued in the same cycle
        for (int k = 0; k < 4; k++) begin wBeats[k] = 64'h40 + 64'(k); wStrbs[k] = 8'hFF; end
        fork
            begin
                axiWrite(8'h03, 20'h04000, 8'd3, 3'd3, 2'b01);
                collectB("conc", 8'h03);
            end
            axiRead(8'h05, 20'h01000, 8'd3, 2'b01, 0);
        join
        for (int k = 0; k < 4; k++) begin
            checkOutput("conc_rdata", rBeats[k], 64'(k + 1));
            checkOutput("conc_rid", 64'(rIds[k]), 64'h05);
        end
        axiRead(8'h06, 20'h04000, 8'd3, 2'b01, 0);
        for (int k = 0; k < 4; k++) checkOutput("conc_wdata", rBeats[k], 64'h40 + 64'(k));

        // Reset pulsed in the middle of an 8-beat read
        @(negedge clk);
        bus.arid = 8'h09; bus.araddr = 20'h01000; bus.arlen = 8'd7;
        bus.arsize = 3'd3; bus.arburst = 2'b01; bus.arvalid = 1'b1;
        guard = 0;
        while (!bus.arready && guard < 50) begin @(negedge clk); guard++; end
        if (guard >= 50) timeoutFail("abort_ar");
        @(negedge clk);
        bus.arvalid = 1'b0;
        bus.rready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("abort_rvalid_before", 64'(bus.rvalid), 64'd1);
        areset_n = 1'b0;
        #1;
        checkOutput("abort_rvalid", 64'(bus.rvalid), 64'd0);
        checkOutput("abort_rdata", bus.rdata, 64'd0);
        checkOutput("abort_arready", 64'(bus.arready), 64'd0);
        bus.rready = 1'b0;
        @(negedge clk);
        areset_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_arready_after", 64'(bus.arready), 64'd1);
        checkOutput("abort_no_r", 64'(bus.rvalid), 64'd0);
        axiRead(8'h0A, 20'h00100, 8'd0, 2'b01, 0);
        checkOutput("abort_reread", rBeats[0], 64'h1122334455667788);
        checkOutput("abort_reread_rid", 64'(rIds[0]), 64'h0A);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
